pc_gen_unit: RTL and testbench
==============================

# pc_gen_unit

Parametrised program-counter generator for the RISC-V core front end. It owns the architectural fetch address and sequences it through reset, linear increment, branch/jump redirect and trap redirect. It presents each address to the instruction-fetch stage over a valid/ready handshake. It sits between the control/branch-resolution logic and instruction memory, replacing the free-running increment-only PC.

## Interface
- XLEN, 32, address/PC width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- IALIGN, 4, instruction alignment and increment in bytes; legal values 2 or 4
- CNT_W, 32, width of fetch-accept counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC (no increment) even if fetch accepted
- branch_taken  in  1  redirect request from branch/jump resolution
- branch_target  in  XLEN  redirect address
- trap  in  1  trap/exception redirect request
- trap_vector  in  XLEN  trap handler address; low log2(IALIGN) bits ignored and forced to 0
- halt  in  1  request to stop fetching
- resume  in  1  leave HALT state
- fetch_ready  in  1  fetch stage accepts current address
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  XLEN  current fetch address
- pc_plus  out  XLEN  pc + IALIGN, combinational (return address)
- misaligned  out  1  one-cycle pulse: rejected misaligned branch_target
- misaligned_addr  out  XLEN  last rejected target
- fetch_count  out  CNT_W  number of accepted fetches

## Operation
- States: BOOT, RUN, HALT.
- Reset (async assert, any state): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, misaligned_addr=0, fetch_count=0.
- BOOT: fetch_valid=0, pc held; goes to RUN unconditionally next clock. Inputs are ignored in BOOT.
- RUN: fetch_valid=1. A fetch is accepted on the cycle when fetch_valid && fetch_ready.
- Next-PC priority in RUN, highest first:
  - trap: pc←trap_vector with low bits cleared.
  - branch_taken with aligned target: pc←branch_target.
  - branch_taken with misaligned target: pc held; misaligned=1 for one cycle; misaligned_addr←branch_target.
  - accepted && !stall: pc←pc+IALIGN.
  - Otherwise: hold.
- A target is misaligned when branch_target[log2(IALIGN)-1:0]≠0.
- Redirects (trap or branch) take effect whether or not fetch_ready is high. The pending request is dropped and replaced by the new pc.
- halt in RUN, with no trap that cycle: go to HALT. The increment/branch update of that same cycle still applies.
- HALT: fetch_valid=0, pc held, branch_taken ignored.
  - resume: go to RUN.
  - trap: load trap_vector and go to RUN (trap wakes the unit).
  - halt and resume together in HALT: resume wins.
- fetch_count increments by 1 per accepted fetch and wraps modulo 2^CNT_W.
- PC arithmetic wraps modulo 2^XLEN (all-ones region + IALIGN → low addresses). No overflow flag.

## Timing
- All state/outputs registered except pc_plus (combinational from pc).
- Redirect latency: inputs sampled at edge N; new pc and fetch_valid visible after edge N; first fetch of new target possible in cycle N+1.
- fetch_valid first rises one cycle after reset deassertion (BOOT lasts exactly one cycle).
- While fetch_valid=1 and fetch_ready=0 with no redirect, pc is stable (handshake rule).
- misaligned is high only the cycle after the offending edge.
- Reset asserted mid-operation clears state immediately, without waiting for clk.

## Test plan
- Reset release, fetch_ready=1 constantly, defaults → fetch_valid rises one cycle after release; pc sequence 0,4,8,12; fetch_count=3 after 3 accepts.
- fetch_ready low 3 cycles at pc=0x10, then high → pc stays 0x10 for 3 cycles, then 0x14; stall=1 with ready=1 → pc held, fetch_count still increments.
- branch_taken=1, target=0x200, same cycle as trap=1, trap_vector=0x803 → pc=0x800; next cycle branch alone to 0x200 → pc=0x200.
- branch_target=0x102 (IALIGN=4) → pc unchanged, misaligned one-cycle pulse, misaligned_addr=0x102; with IALIGN=2 the same target loads.
- halt in RUN → fetch_valid=0, pc held; branch ignored; trap_vector=0x40 → RUN with pc=0x40; separately, resume → RUN at held pc.
- XLEN=32, pc=0xFFFF_FFFC, accept → pc=0x0000_0000; rst_n low mid-stream → pc=RESET_VECTOR and fetch_valid=0 before the next clk edge.

Source files
------------

// File: rtl/pc_gen_unit_if.sv
// Front-end fetch bus between the PC generator and the control/fetch logic.
// Handshake: a fetch is accepted on a rising clk edge with fetch_valid && fetch_ready;
// pc is stable while fetch_valid=1 and fetch_ready=0 unless a redirect replaces it.
interface pc_gen_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic             trap;
  logic [XLEN-1:0]  trap_vector;
  logic             halt;
  logic             resume;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus;
  logic             misaligned;
  logic [XLEN-1:0]  misaligned_addr;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, trap, trap_vector,
           halt, resume, fetch_ready,
    output fetch_valid, pc, pc_plus, misaligned, misaligned_addr, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, trap, trap_vector,
           halt, resume, fetch_ready,
    input  fetch_valid, pc, pc_plus, misaligned, misaligned_addr, fetch_count
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator: owns the fetch address and sequences it through
// boot, linear increment, branch redirect, trap redirect and halt.
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_gen_unit_if.master bus,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(IALIGN);

  state_t           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  mis_addr_q;
  logic             mis_q;
  logic             fv_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             accepted;
  logic             tgt_mis;
  logic [XLEN-1:0]  trap_pc;

  assign accepted = fv_q & bus.fetch_ready;
  assign tgt_mis  = (bus.branch_target & ALIGN_MASK) != '0;
  assign trap_pc  = bus.trap_vector & ~ALIGN_MASK;

  always_comb begin
    pc_d = pc_q;
    unique case (state_q)
      RUN: begin
        if (bus.trap) begin
          pc_d = trap_pc;
        end else if (bus.branch_taken) begin
          // A misaligned target is rejected outright; the pc neither jumps nor advances.
          if (!tgt_mis) pc_d = bus.branch_target;
        end else if (accepted && !bus.stall) begin
          pc_d = pc_q + PC_INC;
        end
      end
      HALT: begin
        if (bus.trap) pc_d = trap_pc;
      end
      default: pc_d = pc_q;
    endcase
  end

  assign cnt_d = accepted ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      fv_q       <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      mis_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          fv_q    <= 1'b1;
        end
        RUN: begin
          if (!bus.trap && bus.branch_taken && tgt_mis) begin
            mis_q      <= 1'b1;
            mis_addr_q <= bus.branch_target;
          end
          if (bus.halt && !bus.trap) begin
            state_q <= HALT;
            fv_q    <= 1'b0;
          end
        end
        HALT: begin
          // Trap wakes the unit; resume beats a simultaneous halt.
          if (bus.resume || bus.trap) begin
            state_q <= RUN;
            fv_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          fv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_valid     = fv_q;
  assign bus.pc              = pc_q;
  assign bus.pc_plus         = pc_q + PC_INC;
  assign bus.misaligned      = mis_q;
  assign bus.misaligned_addr = mis_addr_q;
  assign bus.fetch_count     = cnt_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed vectors, accepted fetch addresses checked via a queue.
module tb_pc_gen_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic clk;
  logic rst_n;
  logic [1:0] state_a;
  logic [1:0] state_b;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  pc_gen_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_a ();
  pc_gen_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_b ();

  pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .IALIGN(4), .CNT_W(CNT_W)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_a),
    .state_o (state_a)
  );

  pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .IALIGN(2), .CNT_W(CNT_W)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_b),
    .state_o (state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [XLEN-1:0] exp_pc);
    exp_q.push_back(exp_pc);
    tick();
  endtask

  task automatic clear_a();
    bus_a.stall         = 1'b0;
    bus_a.branch_taken  = 1'b0;
    bus_a.branch_target = '0;
    bus_a.trap          = 1'b0;
    bus_a.trap_vector   = '0;
    bus_a.halt          = 1'b0;
    bus_a.resume        = 1'b0;
  endtask

  // scoreboard monitor: every accepted fetch must match the next expected address
  always @(negedge clk) begin
    if (rst_n && bus_a.fetch_valid && bus_a.fetch_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fetch_unexpected: got pc 0x%08h, expected no accepted fetch", bus_a.pc);
      end else begin
        chk("fetch_pc", bus_a.pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clear_a();
    bus_a.fetch_ready = 1'b1;
    bus_b.stall = 1'b0; bus_b.branch_taken = 1'b0; bus_b.branch_target = '0;
    bus_b.trap = 1'b0; bus_b.trap_vector = '0; bus_b.halt = 1'b0;
    bus_b.resume = 1'b0; bus_b.fetch_ready = 1'b0;

    tick(); tick();
    chk("rst_fv",       XLEN'(bus_a.fetch_valid), 32'd0);
    chk("rst_pc",       bus_a.pc, 32'h0);
    chk("rst_cnt",      bus_a.fetch_count, 32'd0);
    chk("rst_mis",      XLEN'(bus_a.misaligned), 32'd0);
    chk("rst_mis_addr", bus_a.misaligned_addr, 32'h0);
    chk("rst_state",    XLEN'(state_a), 32'd0);

    rst_n = 1'b1;
    chk("boot_fv", XLEN'(bus_a.fetch_valid), 32'd0);
    tick();
    chk("run_fv",    XLEN'(bus_a.fetch_valid), 32'd1);
    chk("run_pc0",   bus_a.pc, 32'h0);
    chk("run_state", XLEN'(state_a), 32'd1);

    // linear increment
    acc(32'h0); acc(32'h4); acc(32'h8);
    chk("inc_pc12", bus_a.pc, 32'hC);
    chk("inc_cnt3", bus_a.fetch_count, 32'd3);
    acc(32'hC);
    chk("inc_pc10", bus_a.pc, 32'h10);

    // back-pressure holds pc
    bus_a.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", bus_a.pc, 32'h10);
    end
    chk("hold_cnt", bus_a.fetch_count, 32'd4);
    bus_a.fetch_ready = 1'b1;
    acc(32'h10);
    chk("resume_pc14", bus_a.pc, 32'h14);

    // stall: accepted but pc held
    bus_a.stall = 1'b1;
    acc(32'h14);
    bus_a.stall = 1'b0;
    chk("stall_pc",  bus_a.pc, 32'h14);
    chk("stall_cnt", bus_a.fetch_count, 32'd6);

    // trap beats branch, trap vector low bits cleared
    bus_a.fetch_ready   = 1'b0;
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 32'h200;
    bus_a.trap          = 1'b1;
    bus_a.trap_vector   = 32'h803;
    tick();
    chk("trap_pc", bus_a.pc, 32'h800);
    bus_a.trap = 1'b0;
    tick();
    chk("branch_pc", bus_a.pc, 32'h200);

    // misaligned target (IALIGN=4 rejects, IALIGN=2 loads)
    bus_a.branch_target = 32'h102;
    bus_b.branch_taken  = 1'b1;
    bus_b.branch_target = 32'h102;
    tick();
    chk("mis_pc",      bus_a.pc, 32'h200);
    chk("mis_pulse",   XLEN'(bus_a.misaligned), 32'd1);
    chk("mis_addr",    bus_a.misaligned_addr, 32'h102);
    chk("ia2_pc",      bus_b.pc, 32'h102);
    chk("ia2_mis",     XLEN'(bus_b.misaligned), 32'd0);
    chk("ia2_pc_plus", bus_b.pc_plus, 32'h104);
    clear_a();
    bus_b.branch_taken = 1'b0;
    tick();
    chk("mis_drop",      XLEN'(bus_a.misaligned), 32'd0);
    chk("mis_addr_keep", bus_a.misaligned_addr, 32'h102);
    chk("pc_plus",       bus_a.pc_plus, 32'h204);

    // halt: same-cycle increment applies, then branch ignored, trap wakes
    bus_a.fetch_ready = 1'b1;
    bus_a.halt        = 1'b1;
    acc(32'h200);
    bus_a.halt = 1'b0;
    chk("halt_fv",    XLEN'(bus_a.fetch_valid), 32'd0);
    chk("halt_pc",    bus_a.pc, 32'h204);
    chk("halt_cnt",   bus_a.fetch_count, 32'd7);
    chk("halt_state", XLEN'(state_a), 32'd2);
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 32'h300;
    tick();
    chk("halt_br_ign", bus_a.pc, 32'h204);
    bus_a.branch_taken = 1'b0;
    bus_a.trap         = 1'b1;
    bus_a.trap_vector  = 32'h40;
    tick();
    bus_a.trap = 1'b0;
    chk("wake_fv", XLEN'(bus_a.fetch_valid), 32'd1);
    chk("wake_pc", bus_a.pc, 32'h40);
    acc(32'h40);
    bus_a.fetch_ready = 1'b0;

    // halt then halt+resume together: resume wins
    bus_a.halt = 1'b1;
    tick();
    chk("halt2_fv", XLEN'(bus_a.fetch_valid), 32'd0);
    bus_a.resume = 1'b1;
    tick();
    clear_a();
    chk("resume_fv", XLEN'(bus_a.fetch_valid), 32'd1);
    chk("resume_pc", bus_a.pc, 32'h44);

    // address wrap at top of memory
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 32'hFFFF_FFFC;
    tick();
    bus_a.branch_taken = 1'b0;
    chk("top_pc",      bus_a.pc, 32'hFFFF_FFFC);
    chk("top_pc_plus", bus_a.pc_plus, 32'h0);
    bus_a.fetch_ready = 1'b1;
    acc(32'hFFFF_FFFC);
    bus_a.fetch_ready = 1'b0;
    chk("wrap_pc",  bus_a.pc, 32'h0);
    chk("wrap_cnt", bus_a.fetch_count, 32'd9);

    // asynchronous reset mid-stream, checked before the next edge
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 32'h500;
    tick();
    chk("pre_rst_pc", bus_a.pc, 32'h500);
    clear_a();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc",  bus_a.pc, 32'h0);
    chk("arst_fv",  XLEN'(bus_a.fetch_valid), 32'd0);
    chk("arst_cnt", bus_a.fetch_count, 32'd0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
